// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing for the five-stage MIPS core.
// Detects load-use, branch and MDU-occupancy hazards, tracks the multiply/
// divide busy counter and sequences exception/interrupt entry and eret return.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       use_rs_D,
  input  logic       use_rt_D,
  input  logic       branch_D,
  input  logic       md_D,
  input  logic       eret_D,
  input  logic [4:0] wr_E,
  input  logic       regwrite_E,
  input  logic       load_E,
  input  logic [4:0] wr_M,
  input  logic       load_M,
  input  logic       md_start_E,
  input  logic       is_div_E,
  input  logic       exc_M,
  input  logic       int_req,
  input  logic       ie,
  output logic       pc_en,
  output logic       en_D,
  output logic       clr_D,
  output logic       clr_E,
  output logic       int_clr,
  output logic       epc_we,
  output logic       pc_vec,
  output logic       exl,
  output logic       mdu_busy
);

  typedef enum logic [1:0] {NORMAL, ENTER, HANDLER} state_t;

  state_t           state;
  logic [CNT_W-1:0] md_cnt;

  logic rs_hit_E, rt_hit_E, rs_hit_M, rt_hit_M;
  logic dep_E, dep_M;
  logic ld_haz, br_haz, md_haz, stall, take, cnt_nz;

  // Source/destination matching; register 0 never creates a dependence.
  always_comb begin
    rs_hit_E = use_rs_D && (rs_D != '0) && (rs_D == wr_E);
    rt_hit_E = use_rt_D && (rt_D != '0) && (rt_D == wr_E);
    rs_hit_M = use_rs_D && (rs_D != '0) && (rs_D == wr_M);
    rt_hit_M = use_rt_D && (rt_D != '0) && (rt_D == wr_M);
    dep_E    = rs_hit_E || rt_hit_E;
    dep_M    = rs_hit_M || rt_hit_M;
  end

  // Hazard detection and exception-entry decision.
  always_comb begin
    cnt_nz = (md_cnt != '0);
    ld_haz = load_E && dep_E;
    br_haz = branch_D && ((regwrite_E && dep_E) || (load_M && dep_M));
    md_haz = md_D && (cnt_nz || md_start_E);
    stall  = ld_haz || br_haz || md_haz;
    // Entry is suppressed in ENTER so the flushed stages cannot re-trigger it.
    take   = (state != ENTER) && (exc_M || (int_req && ie && !exl));
  end

  // Pipeline control outputs; entry overrides any stall, reset forces all low.
  always_comb begin
    pc_en    = 1'b0;
    en_D     = 1'b0;
    clr_D    = 1'b0;
    clr_E    = 1'b0;
    int_clr  = 1'b0;
    epc_we   = 1'b0;
    pc_vec   = 1'b0;
    mdu_busy = 1'b0;
    if (reset) begin
      mdu_busy = cnt_nz;
      if (take) begin
        int_clr = 1'b1;
        epc_we  = 1'b1;
        pc_vec  = 1'b1;
        pc_en   = 1'b1;
        en_D    = 1'b1;
        clr_E   = 1'b1;
      end else begin
        pc_en = !stall;
        en_D  = !stall;
        clr_E = stall;
        clr_D = eret_D && !stall;
      end
    end
  end

  // MDU occupancy counter: load on start (restart reloads), else count down to 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (md_start_E) begin
      md_cnt <= is_div_E ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  // Exception/interrupt sequencing with registered exception level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= NORMAL;
      exl   <= 1'b0;
    end else begin
      unique case (state)
        NORMAL: begin
          if (take) begin
            state <= ENTER;
            exl   <= 1'b1;
          end
        end
        ENTER: begin
          state <= HANDLER;
          exl   <= 1'b1;
        end
        HANDLER: begin
          if (take) begin
            state <= ENTER;
            exl   <= 1'b1;
          end else if (eret_D && !stall) begin
            state <= NORMAL;
            exl   <= 1'b0;
          end
        end
        default: begin
          state <= NORMAL;
          exl   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, wr_E, wr_M;
  logic       use_rs_D, use_rt_D, branch_D, md_D, eret_D;
  logic       regwrite_E, load_E, load_M, md_start_E, is_div_E;
  logic       exc_M, int_req, ie;
  logic       pc_en, en_D, clr_D, clr_E, int_clr, epc_we, pc_vec, exl, mdu_busy;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .branch_D(branch_D), .md_D(md_D), .eret_D(eret_D),
    .wr_E(wr_E), .regwrite_E(regwrite_E), .load_E(load_E),
    .wr_M(wr_M), .load_M(load_M),
    .md_start_E(md_start_E), .is_div_E(is_div_E),
    .exc_M(exc_M), .int_req(int_req), .ie(ie),
    .pc_en(pc_en), .en_D(en_D), .clr_D(clr_D), .clr_E(clr_E),
    .int_clr(int_clr), .epc_we(epc_we), .pc_vec(pc_vec),
    .exl(exl), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: remaining MDU busy cycles, handler level, entry cycle.
  int md_left    = 0;
  bit m_exl      = 1'b0;
  bit m_entering = 1'b0;
  bit m_valid    = 1'b0;

  // Outputs observed in the most recent cycle, for directed counting.
  logic s_pc_en, s_clr_D, s_int_clr, s_exl, s_busy;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // True when r is a nonzero register that the D-stage instruction reads.
  function automatic bit reads(input logic [4:0] r);
    logic [4:0] src [2];
    bit         used[2];
    bit         hit = 1'b0;
    src[0] = rs_D;     src[1] = rt_D;
    used[0] = use_rs_D; used[1] = use_rt_D;
    for (int i = 0; i < 2; i++)
      if (used[i] && src[i] != 5'd0 && src[i] == r) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit m_stall();
    bit ld = load_E && reads(wr_E);
    bit br = branch_D && ((regwrite_E && reads(wr_E)) || (load_M && reads(wr_M)));
    bit md = md_D && (md_left > 0 || md_start_E);
    return ld || br || md;
  endfunction

  function automatic bit m_take();
    return !m_entering && (exc_M || (int_req && ie && !m_exl));
  endfunction

  task automatic idle();
    reset = 1'b1;
    rs_D = '0; rt_D = '0; wr_E = '0; wr_M = '0;
    use_rs_D = 0; use_rt_D = 0; branch_D = 0; md_D = 0; eret_D = 0;
    regwrite_E = 0; load_E = 0; load_M = 0; md_start_E = 0; is_div_E = 0;
    exc_M = 0; int_req = 0; ie = 0;
  endtask

  // One clock cycle: check all outputs against the model, then advance the model.
  task automatic cycle();
    bit st, tk, on;
    #2;
    st = m_stall();
    tk = m_take();
    on = reset;
    s_pc_en = pc_en; s_clr_D = clr_D; s_int_clr = int_clr; s_exl = exl; s_busy = mdu_busy;
    check("pc_en",    pc_en,    on && (tk || !st));
    check("en_D",     en_D,     on && (tk || !st));
    check("clr_D",    clr_D,    on && eret_D && !st && !tk);
    check("clr_E",    clr_E,    on && (tk || st));
    check("int_clr",  int_clr,  on && tk);
    check("epc_we",   epc_we,   on && tk);
    check("pc_vec",   pc_vec,   on && tk);
    check("mdu_busy", mdu_busy, on && md_left > 0);
    if (m_valid) check("exl", exl, m_exl);
    @(posedge clk);
    if (!reset) begin
      md_left = 0; m_exl = 0; m_entering = 0; m_valid = 1;
    end else begin
      if (md_start_E) md_left = is_div_E ? 10 : 5;
      else if (md_left > 0) md_left--;
      if (tk) begin
        m_entering = 1; m_exl = 1;
      end else if (m_entering) begin
        m_entering = 0;
      end else if (m_exl && eret_D && !st) begin
        m_exl = 0;
      end
    end
    #1;
  endtask

  int cnt, cnt2;

  initial begin
    idle();
    reset = 1'b0;
    cycle(); cycle();

    // Load-use on $8: one stall cycle; same with rs=0: none.
    idle(); load_E = 1; wr_E = 8; rs_D = 8; use_rs_D = 1;
    cnt = 0;
    cycle(); cnt += !s_pc_en;
    load_E = 0;
    cycle(); cnt += !s_pc_en;
    check("loaduse_cycles", cnt, 1);
    idle(); load_E = 1; wr_E = 0; rs_D = 0; use_rs_D = 1;
    cycle();
    check("loaduse_r0", s_pc_en, 1);

    // Branch against a load: two stall cycles.
    idle(); branch_D = 1; rs_D = 5; use_rs_D = 1; load_E = 1; regwrite_E = 1; wr_E = 5;
    cnt = 0;
    cycle(); cnt += !s_pc_en;
    load_E = 0; regwrite_E = 0; wr_E = 0; load_M = 1; wr_M = 5;
    cycle(); cnt += !s_pc_en;
    load_M = 0;
    cycle(); cnt += !s_pc_en;
    check("br_load_cycles", cnt, 2);

    // Branch against an ALU result: one stall cycle.
    idle(); branch_D = 1; rs_D = 5; use_rs_D = 1; regwrite_E = 1; wr_E = 5;
    cnt = 0;
    cycle(); cnt += !s_pc_en;
    regwrite_E = 0; wr_E = 0; wr_M = 5;
    cycle(); cnt += !s_pc_en;
    check("br_alu_cycles", cnt, 1);

    // Divide then md_D held: 10 busy cycles, 11 stalls, released on the 12th.
    idle();
    for (int i = 0; i < 12; i++) cycle();
    md_start_E = 1; is_div_E = 1; md_D = 1;
    cnt = 0; cnt2 = 0;
    cycle(); cnt += !s_pc_en; cnt2 += s_busy;
    md_start_E = 0; is_div_E = 0;
    for (int i = 0; i < 11; i++) begin
      cycle(); cnt += !s_pc_en; cnt2 += s_busy;
    end
    check("mdu_stall_cycles", cnt, 11);
    check("mdu_busy_cycles", cnt2, 10);
    check("mdu_release", s_pc_en, 1);

    // Exception held two cycles: single entry, then interrupts ignored in handler.
    idle(); exc_M = 1;
    cnt = 0;
    cycle(); cnt += s_int_clr;
    cycle(); cnt += s_int_clr;
    check("exc_entry_pulses", cnt, 1);
    check("exl_after_take", s_exl, 1);
    idle(); int_req = 1; ie = 1;
    cnt = 0;
    cycle(); cnt += s_int_clr;
    cycle(); cnt += s_int_clr;
    check("int_in_handler", cnt, 0);
    idle(); eret_D = 1;
    cycle();
    check("eret_clr_D", s_clr_D, 1);
    idle();
    cycle();
    check("eret_exl", s_exl, 0);

    // Return blocked by a load-use stall until it clears.
    idle(); exc_M = 1; cycle();
    idle(); cycle(); cycle();
    eret_D = 1; load_E = 1; wr_E = 8; rs_D = 8; use_rs_D = 1;
    cycle();
    check("eret_stalled_clr_D", s_clr_D, 0);
    check("eret_stalled_exl", s_exl, 1);
    load_E = 0;
    cycle();
    check("eret_late_clr_D", s_clr_D, 1);
    idle(); cycle();
    check("eret_late_exl", s_exl, 0);

    // Reset mid-divide with counter at 6 while in the handler.
    idle(); exc_M = 1; cycle();
    idle(); cycle();
    md_start_E = 1; is_div_E = 1; cycle();
    idle();
    for (int i = 0; i < 4; i++) cycle();
    reset = 0;
    cycle();
    check("rst_pc_en", s_pc_en, 0);
    check("rst_busy", s_busy, 0);
    idle(); cycle();
    check("post_rst_busy", s_busy, 0);
    check("post_rst_exl", s_exl, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 49) != 0);
      rs_D       = 5'($urandom_range(0, 3));
      rt_D       = 5'($urandom_range(0, 3));
      wr_E       = 5'($urandom_range(0, 3));
      wr_M       = 5'($urandom_range(0, 3));
      use_rs_D   = 1'($urandom);
      use_rt_D   = 1'($urandom);
      branch_D   = ($urandom_range(0, 3) == 0);
      md_D       = ($urandom_range(0, 3) == 0);
      eret_D     = ($urandom_range(0, 3) == 0);
      regwrite_E = 1'($urandom);
      load_E     = ($urandom_range(0, 3) == 0);
      load_M     = ($urandom_range(0, 3) == 0);
      md_start_E = ($urandom_range(0, 7) == 0);
      is_div_E   = 1'($urandom);
      exc_M      = ($urandom_range(0, 15) == 0);
      int_req    = ($urandom_range(0, 3) == 0);
      ie         = 1'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
